// File: rtl/pe_controller.sv
// Sequencer for one PE: filter load, MAC/shift/write per OFM word.
// Optional PE_CTRL_FILTER_REUSE_EN adds reuse_filt to skip the filter load.
module pe_controller #(
    parameter int FILT_LEN = 16,
    parameter int LANES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  filt_base,
    input  logic [7:0]  ofm_base,
    input  logic [7:0]  num_out,
`ifdef PE_CTRL_FILTER_REUSE_EN
    input  logic        reuse_filt,
`endif
    input  logic        ifm_valid,
    output logic        ifm_ready,
    output logic [15:0] en1,
    output logic [3:0]  sel,
    output logic        en12,
    output logic        rst12,
    output logic        en10,
    output logic        wr,
    output logic [7:0]  muxOut,
    output logic        busy,
    output logic        done
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        IDLE, LOAD, CLR, MAC, SHIFT, WRITE, DONE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    filt_q, ofm_q, num_q;
    logic [7:0]    word_cnt, mux_q;
    logic [1:0]    load_cnt;
    logic [3:0]    tap_cnt;
    logic [LW-1:0] lane_cnt;
    logic          skip_load;
    logic          tap_last, lane_last, word_last;

`ifdef PE_CTRL_FILTER_REUSE_EN
    assign skip_load = reuse_filt;
`else
    assign skip_load = 1'b0;
`endif

    assign tap_last  = (tap_cnt == 4'(FILT_LEN - 1));
    assign lane_last = (lane_cnt == LW'(LANES - 1));
    assign word_last = (word_cnt == num_q - 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) begin
                if (!skip_load)         state_d = LOAD;
                else if (num_out == 0)  state_d = DONE;
                else                    state_d = CLR;
            end
            LOAD: if (load_cnt == 2'd3)
                state_d = (num_q == 8'd0) ? DONE : CLR;
            CLR:   state_d = MAC;
            MAC:   if (ifm_valid && tap_last) state_d = SHIFT;
            SHIFT: state_d = lane_last ? WRITE : CLR;
            WRITE: state_d = word_last ? DONE : CLR;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters and job parameters; only IDLE samples the request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q   <= '0;
            ofm_q    <= '0;
            num_q    <= '0;
            load_cnt <= '0;
            tap_cnt  <= '0;
            lane_cnt <= '0;
            word_cnt <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    filt_q   <= filt_base;
                    ofm_q    <= ofm_base;
                    num_q    <= num_out;
                    load_cnt <= '0;
                    lane_cnt <= '0;
                    word_cnt <= '0;
                end
                LOAD:  load_cnt <= load_cnt + 2'd1;
                CLR:   tap_cnt  <= '0;
                MAC:   if (ifm_valid) tap_cnt <= tap_cnt + 4'd1;
                SHIFT: lane_cnt <= lane_cnt + LW'(1);
                WRITE: begin
                    lane_cnt <= '0;
                    word_cnt <= word_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // The address bus keeps whatever LOAD or WRITE drove last
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mux_q <= '0;
        else      mux_q <= muxOut;
    end

    always_comb begin
        ifm_ready = 1'b0;
        en1       = '0;
        sel       = '0;
        en12      = 1'b0;
        rst12     = 1'b0;
        en10      = 1'b0;
        wr        = 1'b0;
        muxOut    = mux_q;
        done      = 1'b0;
        busy      = (state_q != IDLE);
        unique case (state_q)
            LOAD: begin
                en1    = 16'hF << {load_cnt, 2'b00};
                muxOut = filt_q + {6'd0, load_cnt};
            end
            CLR: rst12 = 1'b1;
            MAC: begin
                sel       = tap_cnt;
                ifm_ready = 1'b1;
                en12      = ifm_valid;
            end
            SHIFT: en10 = 1'b1;
            WRITE: begin
                wr     = 1'b1;
                muxOut = ofm_q + word_cnt;
            end
            DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pe_controller.sv
// Directed bench for pe_controller: job table plus reset-in-flight sequence.
// Expected per-cycle outputs come from a phase model of the job.
module tb_pe_controller;

    localparam int FL = 16;
    localparam int LN = 4;

    logic        clk, rst, start;
    logic [7:0]  filt_base, ofm_base, num_out;
    logic        reuse_filt;
    logic        ifm_valid, ifm_ready;
    logic [15:0] en1;
    logic [3:0]  sel;
    logic        en12, rst12, en10, wr, busy, done;
    logic [7:0]  muxOut;

    pe_controller #(.FILT_LEN(FL), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .start(start),
        .filt_base(filt_base), .ofm_base(ofm_base), .num_out(num_out),
`ifdef PE_CTRL_FILTER_REUSE_EN
        .reuse_filt(reuse_filt),
`endif
        .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
        .en1(en1), .sel(sel), .en12(en12), .rst12(rst12), .en10(en10),
        .wr(wr), .muxOut(muxOut), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] en1;
        logic [3:0]  sel;
        logic        ifm_ready;
        logic        en12;
        logic        rst12;
        logic        en10;
        logic        wr;
        logic [7:0]  mux;
        logic        busy;
        logic        done;
    } rec_t;

    typedef struct {
        logic [7:0] fb, ob, n;
        bit         reuse;
        int         gap_at, gap_len, pulse_at;
        int         exp_done, exp_wr;
    } vec_t;

    rec_t       exp_q[$];
    vec_t       vecs[$];
    logic [7:0] last_mux;
    int         total, bad;

    function automatic rec_t sample(input bit chk_sel);
        rec_t r;
        r.en1 = en1; r.sel = chk_sel ? sel : 4'd0;
        r.ifm_ready = ifm_ready; r.en12 = en12; r.rst12 = rst12;
        r.en10 = en10; r.wr = wr; r.mux = muxOut;
        r.busy = busy; r.done = done;
        return r;
    endfunction

    function automatic rec_t base_rec(input bit b);
        rec_t r;
        r = '0;
        r.mux = last_mux;
        r.busy = b;
        return r;
    endfunction

    task automatic chk(input string nm, input int idx, input rec_t a, input rec_t e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    // Build the expected cycle-by-cycle response after the accept edge
    task automatic build(input vec_t v);
        rec_t r;
        int   tap;
        exp_q.delete();
        if (!v.reuse)
            for (int k = 0; k < 4; k++) begin
                r = base_rec(1);
                r.en1 = 16'hF << (4 * k);
                r.mux = v.fb + 8'(k);
                last_mux = r.mux;
                exp_q.push_back(r);
            end
        for (int w = 0; w < int'(v.n); w++) begin
            for (int l = 0; l < LN; l++) begin
                r = base_rec(1); r.rst12 = 1; exp_q.push_back(r);
                tap = 0;
                while (tap < FL) begin
                    r = base_rec(1);
                    r.sel = 4'(tap);
                    r.ifm_ready = 1;
                    if (exp_q.size() >= v.gap_at &&
                        exp_q.size() < v.gap_at + v.gap_len) begin
                        r.en12 = 0;
                    end else begin
                        r.en12 = 1;
                        tap++;
                    end
                    exp_q.push_back(r);
                end
                r = base_rec(1); r.en10 = 1; exp_q.push_back(r);
            end
            r = base_rec(1);
            r.wr = 1;
            r.mux = v.ob + 8'(w);
            last_mux = r.mux;
            exp_q.push_back(r);
        end
        r = base_rec(1); r.done = 1; exp_q.push_back(r);
    endtask

    // Called just after a negedge; the next posedge accepts the start
    task automatic run_job(input vec_t v);
        int   first_done, wr_n;
        rec_t a;
        first_done = -1;
        wr_n = 0;
        build(v);
        filt_base = v.fb; ofm_base = v.ob; num_out = v.n;
        reuse_filt = v.reuse;
        ifm_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            ifm_valid = !(i >= v.gap_at && i < v.gap_at + v.gap_len);
            start = (i == v.pulse_at);
            @(negedge clk);
            a = sample(exp_q[i].ifm_ready);
            chk("trace", i, a, exp_q[i]);
            if (done && first_done < 0) first_done = i;
            if (wr) wr_n++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        ifm_valid = 1'b0;
        @(negedge clk);
        chk("idle_after", 0, sample(0), base_rec(0));
        chk_int("done_latency", first_done + 1, v.exp_done);
        chk_int("wr_count", wr_n, v.exp_wr);
    endtask

    initial begin
        int   wr_n;
        total = 0; bad = 0;
        last_mux = 8'h00;
        rst = 1'b0; start = 1'b0; ifm_valid = 1'b0; reuse_filt = 1'b0;
        filt_base = '0; ofm_base = '0; num_out = '0;

        //             fb     ob     n     reuse gap_at len pulse done wr
        vecs.push_back('{8'h10, 8'h40, 8'd1, 0, -1, 0, -1, 78, 1});
        vecs.push_back('{8'h10, 8'h40, 8'd1, 0,  9, 3, -1, 81, 1});
        vecs.push_back('{8'h20, 8'hFF, 8'd2, 0, -1, 0, -1, 151, 2});
        vecs.push_back('{8'h10, 8'h40, 8'd1, 0, -1, 0, 30, 78, 1});
        vecs.push_back('{8'h33, 8'h80, 8'd0, 0, -1, 0,  2,  5, 0});
        vecs.push_back('{8'hFE, 8'h10, 8'd1, 0, -1, 0, -1, 78, 1});
`ifdef PE_CTRL_FILTER_REUSE_EN
        vecs.push_back('{8'h10, 8'h40, 8'd1, 1, -1, 0, -1, 74, 1});
`endif

        #12;
        chk("reset", 0, sample(1), rec_t'(0));
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[j]) run_job(vecs[j]);

        // Reset while word 0 is in MAC
        filt_base = 8'h10; ofm_base = 8'h40; num_out = 8'd1;
        ifm_valid = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        total++;
        if (ifm_ready !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst_mac: ifm_ready=%b want 1", ifm_ready);
        end
        rst = 1'b0;
        #1;
        chk("rst_async", 0, sample(1), rec_t'(0));
        wr_n = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_hold", c, sample(1), rec_t'(0));
            if (wr) wr_n++;
        end
        rst = 1'b1;
        last_mux = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wr) wr_n++;
        end
        chk_int("rst_no_wr", wr_n, 0);
        chk("rst_idle", 0, sample(1), rec_t'(0));
        run_job(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: sim time exceeded limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pe_controller.md
PE_CONTROLLER -- requirements
Module: pe_controller

Interface
REQ-001 Parameter FILT_LEN, default 16: filter taps per output; legal values 1..16.
REQ-002 Parameter LANES, default 4: MAC results per OFM word; matches the shift-register depth.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle job request; sampled in IDLE only.
REQ-006 filt_base  in  8  memory address of filter word 0; latched on accepted start.
REQ-007 ofm_base  in  8  memory address of OFM word 0; latched on accepted start.
REQ-008 num_out  in  8  OFM words to produce; latched on accepted start.
REQ-009 ifm_valid  in  1  the MAC operand on mac2_in is valid this cycle.
REQ-010 ifm_ready  out  1  the controller consumes the operand this cycle.
REQ-011 en1  out  16  filter-buffer byte write enables.
REQ-012 sel  out  4  filter tap select for the 16:1 mux.
REQ-013 en12  out  1  MAC accumulate enable.
REQ-014 rst12  out  1  MAC accumulator clear, synchronous to the MAC.
REQ-015 en10  out  1  shift-register shift enable.
REQ-016 wr  out  1  OFM write strobe.
REQ-017 muxOut  out  8  memory address.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 done  out  1  one-cycle job-complete pulse.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, CLR, MAC, SHIFT, WRITE and DONE. All outputs are decoded from registered state and counters only, with no input-to-output combinational paths except ifm_ready and en12.
REQ-021 In IDLE, a start=1 SHALL latch the inputs, clear load_cnt, lane_cnt and word_cnt, and move to LOAD. A start in any other state is ignored.
REQ-022 In LOAD, for cycle k=0..3: muxOut=filt_base+k (mod 256) and en1=16'hF<<(4k). After k=3 the FSM moves to CLR, or to DONE if num_out==0.
REQ-023 CLR SHALL last exactly one cycle: rst12=1, tap_cnt cleared, next state MAC.
REQ-024 In MAC: sel=tap_cnt, ifm_ready=1, en12=ifm_valid. On ifm_valid, tap_cnt increments. A transfer with tap_cnt==FILT_LEN-1 moves the FSM to SHIFT. With ifm_valid=0, the FSM stalls with no state change.
REQ-025 SHIFT SHALL last exactly one cycle with en10=1 and lane_cnt incremented. Next state is WRITE when lane_cnt was LANES-1, else CLR.
REQ-026 WRITE SHALL last one cycle with wr=1 and muxOut=ofm_base+word_cnt (mod 256), lane_cnt cleared and word_cnt incremented. Next state is DONE when word_cnt was num_out-1, else CLR.
REQ-027 DONE SHALL last one cycle with done=1, then move to IDLE.
REQ-028 Outside LOAD and WRITE, muxOut SHALL hold its last driven value. en1, en12, rst12, en10, wr and ifm_ready SHALL be 0 except as stated above.
REQ-029 Latency: with ifm_valid held at 1 and start accepted at edge t, done is high in cycle t+5+N*(LANES*(FILT_LEN+2)+1). For the defaults this is t+5+73N.
REQ-030 Address arithmetic SHALL wrap modulo 256 with no error indication.

Reset
REQ-031 rst=0 at any time, including mid-job, SHALL force IDLE and zero all counters and latched registers.
REQ-032 While rst=0, all outputs SHALL be 0, including muxOut=8'h00.
REQ-033 The first start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-034 Macro PE_CTRL_FILTER_REUSE_EN defined: an extra input reuse_filt (1 bit) is added, latched on start. When reuse_filt=1, the FSM goes IDLE->CLR (or ->DONE if num_out==0), skipping LOAD, and latency drops by 4 cycles.
REQ-035 Macro not defined: no reuse_filt port exists, and LOAD always runs.

Verification
REQ-036 Reset, then start with filt_base=8'h10, ofm_base=8'h40, num_out=1, and ifm_valid=1. Required response: en1=000F,00F0,0F00,F000 with muxOut=10..13; four rst12 pulses; sel sweeps 0..15 four times; four en10 pulses; one wr at muxOut=40; done at t+78.
REQ-037 Same job, with ifm_valid low for 3 cycles during the 5th tap. Required response: sel holds at 4 and en12=0 during the gap; done is delayed by exactly 3 cycles.
REQ-038 num_out=2 with ofm_base=8'hFF. Required response: wr at muxOut=FF, then at 00 (wrap); done at t+151.
REQ-039 Assert rst=0 during the MAC state of word 0. Required response: outputs go to 0 immediately and no wr occurs. A fresh start then completes normally.
REQ-040 start pulsed while busy, then num_out=0. Required response: the extra start is ignored; with num_out=0, LOAD is followed by done and no wr.
REQ-041 With PE_CTRL_FILTER_REUSE_EN defined and reuse_filt=1, num_out=1. Required response: en1 is never asserted and done is at t+74.
